// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal transmitter: header field widths,
// the packet header layout, TX control states and the edge-terminal check.
package mesh_pkg;

  localparam int unsigned NXT_W  = 8;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned MODE_W = 1;
  localparam int unsigned HDR_W  = NXT_W + ROW_W + COL_W + MODE_W;

  // Header portion of a mesh packet; the payload is appended below mode.
  typedef struct packed {
    logic [NXT_W-1:0]  nxt_jump;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [MODE_W-1:0] mode;
  } mesh_pkt_t;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_ACTIVE = 2'd1,
    TX_FULL   = 2'd2
  } tx_state_e;

  // A destination is legal only when it names a terminal on the mesh rim:
  // top/bottom rim rows with an in-range column, or left/right rim columns
  // with an in-range row. Corners are not terminals.
  function automatic logic is_edge_dest(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col,
    input int unsigned      rows,
    input int unsigned      colums
  );
    int unsigned r;
    int unsigned c;
    logic        row_rim;
    logic        col_rim;
    r       = {{(32-ROW_W){1'b0}}, row};
    c       = {{(32-COL_W){1'b0}}, col};
    row_rim = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= colums);
    col_rim = ((c == 0) || (c == colums + 1)) && (r >= 1) && (r <= rows);
    return row_rim || col_rim;
  endfunction

endpackage

// File: rtl/mesh_tx_fifo.sv
// First-word-fall-through buffer for outgoing mesh packets. The caller only
// asserts i_push/i_pop when the operation is legal; the head word reads as
// zero while the buffer is empty.
module mesh_tx_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage write; no reset needed since empty reads are masked to zero.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (i_pop && !i_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/mesh_term_tx.sv
// Terminal-side mesh transmitter: formats client requests into mesh packets,
// rejects non-rim destinations, buffers packets and presents them to the mesh.
// Optional statistics counters are built when MESH_TERM_TX_STATS_EN is defined.
module mesh_term_tx
  import mesh_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [COL_W-1:0]     wr_col,
  input  logic                 wr_mode,
  input  logic [pckg_sz-18:0]  wr_payload,
  output logic                 wr_full,
  output logic                 wr_err,
  output logic                 pndng_i_in,
  output logic [pckg_sz-1:0]   data_out_i_in,
  input  logic                 popin,
  output logic                 pop_err
`ifdef MESH_TERM_TX_STATS_EN
  ,
  output logic [31:0]          tx_cnt,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(fifo_depth) + 1;

  mesh_pkt_t        w_hdr;
  logic [pckg_sz-1:0] w_pkt;
  logic             w_legal;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  tx_state_e        r_state;
  logic             r_pndng;
  logic             r_full;
  logic             r_wr_err;
  logic             r_pop_err;

  assign w_hdr   = '{nxt_jump: '0, row: wr_row, col: wr_col, mode: wr_mode};
  assign w_pkt   = {w_hdr, wr_payload};
  assign w_legal = is_edge_dest(wr_row, wr_col, ROWS, COLUMS);

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign w_pop   = popin && !w_empty;
  assign w_push  = wr_en && w_legal && (!w_full || popin);
  assign w_drop  = wr_en && !w_push;

  mesh_tx_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pkt),
    .o_data  (data_out_i_in),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Occupancy after this edge, used to steer the control FSM.
  always_comb begin
    w_cnt_nxt = w_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = w_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_cnt_nxt = w_count - CNT_W'(1);
    end
  end

  // Control FSM with registered pending/full outputs tracking buffer occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= TX_IDLE;
      r_pndng <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_push) begin
            r_state <= TX_ACTIVE;
            r_pndng <= 1'b1;
          end
        end
        TX_ACTIVE: begin
          if (w_cnt_nxt == CNT_W'(fifo_depth)) begin
            r_state <= TX_FULL;
            r_full  <= 1'b1;
          end else if (w_cnt_nxt == '0) begin
            r_state <= TX_IDLE;
            r_pndng <= 1'b0;
          end
        end
        TX_FULL: begin
          if (w_pop && !w_push) begin
            r_state <= TX_ACTIVE;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_pndng <= 1'b0;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_err  <= 1'b0;
      r_pop_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_wr_err <= 1'b1;
      end
      if (popin && w_empty) begin
        r_pop_err <= 1'b1;
      end
    end
  end

  assign pndng_i_in = r_pndng;
  assign wr_full    = r_full;
  assign wr_err     = r_wr_err;
  assign pop_err    = r_pop_err;

`ifdef MESH_TERM_TX_STATS_EN
  logic [31:0] r_tx_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating counters of packets delivered to the mesh and pushes dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop && (r_tx_cnt != '1)) begin
        r_tx_cnt <= r_tx_cnt + 32'd1;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign tx_cnt   = r_tx_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  // Statistics hardware is not present in this build.
`endif

endmodule
